// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_pkg
// Purpose  : Shared types and constants for the UART transmit arbiter.
// Revision : 1.0
// ============================================================================
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HEADER = 2'd1,
        ARB_DATA   = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_W = 16;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker: first set request at or
//            after ptr, wrapping past N-1.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_first;
    logic [IDW:0]   w_sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_shift = {req, req} >> ptr;
        w_rot   = w_shift[N-1:0];
        w_first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_first = IDW'(i);
            end
        end
        w_sum = {1'b0, w_first} + {1'b0, ptr};
        if (w_sum >= (IDW + 1)'(N)) begin
            w_sum = w_sum - (IDW + 1)'(N);
        end
        idx = w_sum[IDW-1:0];
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Packet-granular round-robin sharing of one uart_tx among
//            NUM_CLIENTS byte streams, with optional channel header byte.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int                   NUM_CLIENTS    = 4,
    parameter bit                   HEADER_EN      = 1'b1,
    parameter logic [7:0]           HEADER_BASE    = 8'hF0,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd65535,
    localparam int                  IDW            = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_CLIENTS-1:0]   i_valid,
    input  logic [8*NUM_CLIENTS-1:0] i_data,
    input  logic [NUM_CLIENTS-1:0]   i_last,
    output logic [NUM_CLIENTS-1:0]   o_ready,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy,
    output logic [IDW-1:0]           o_grant_id,
    output logic                     o_timeout_pulse
);

    arb_state_t           r_state, w_state_nxt;
    logic [IDW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [IDW-1:0]       r_grant_id, w_grant_id_nxt;
    logic [TIMEOUT_W-1:0] r_stall_cnt, w_stall_cnt_nxt;
    logic                 r_timeout_pulse, w_timeout_pulse_nxt;

    logic                   w_pick_any;
    logic [IDW-1:0]         w_pick_idx;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic [7:0]             w_g_data;
    logic [IDW-1:0]         w_g_succ;
    logic [NUM_CLIENTS-1:0] w_ready;
    logic                   w_tx_valid;
    logic [7:0]             w_tx_data;

    rr_pick #(
        .N   (NUM_CLIENTS),
        .IDW (IDW)
    ) u_rr_pick (
        .req (i_valid),
        .ptr (r_rr_ptr),
        .any (w_pick_any),
        .idx (w_pick_idx)
    );

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (r_grant_id == IDW'(k)) begin
                w_g_valid = i_valid[k];
                w_g_last  = i_last[k];
                w_g_data  = i_data[8*k +: 8];
            end
        end
    end

    assign w_g_succ = (r_grant_id == IDW'(NUM_CLIENTS - 1)) ? '0 : r_grant_id + IDW'(1);

    always_comb begin
        w_state_nxt         = r_state;
        w_rr_ptr_nxt        = r_rr_ptr;
        w_grant_id_nxt      = r_grant_id;
        w_stall_cnt_nxt     = r_stall_cnt;
        w_timeout_pulse_nxt = 1'b0;
        w_tx_valid          = 1'b0;
        w_tx_data           = '0;
        w_ready             = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    w_grant_id_nxt  = w_pick_idx;
                    w_stall_cnt_nxt = '0;
                    w_state_nxt     = HEADER_EN ? ARB_HEADER : ARB_DATA;
                end
            end
            ARB_HEADER: begin
                w_tx_valid = 1'b1;
                w_tx_data  = HEADER_BASE + 8'(r_grant_id);
                if (i_tx_ready) begin
                    w_state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                w_tx_valid = w_g_valid;
                w_tx_data  = w_g_data;
                for (int k = 0; k < NUM_CLIENTS; k++) begin
                    if (r_grant_id == IDW'(k)) begin
                        w_ready[k] = i_tx_ready;
                    end
                end
                // A valid byte waiting on a busy uart is not a stall.
                if (w_g_valid) begin
                    w_stall_cnt_nxt = '0;
                    if (i_tx_ready && w_g_last) begin
                        w_state_nxt  = ARB_IDLE;
                        w_rr_ptr_nxt = w_g_succ;
                    end
                end else if (TIMEOUT_CYCLES != '0) begin
                    if (r_stall_cnt == TIMEOUT_CYCLES - TIMEOUT_W'(1)) begin
                        w_state_nxt         = ARB_IDLE;
                        w_rr_ptr_nxt        = w_g_succ;
                        w_stall_cnt_nxt     = '0;
                        w_timeout_pulse_nxt = 1'b1;
                    end else begin
                        w_stall_cnt_nxt = r_stall_cnt + TIMEOUT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ARB_IDLE;
            r_rr_ptr        <= '0;
            r_grant_id      <= '0;
            r_stall_cnt     <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_grant_id      <= w_grant_id_nxt;
            r_stall_cnt     <= w_stall_cnt_nxt;
            r_timeout_pulse <= w_timeout_pulse_nxt;
        end
    end

    assign o_ready         = w_ready;
    assign o_tx_valid      = w_tx_valid;
    assign o_tx_data       = w_tx_data;
    assign o_busy          = (r_state != ARB_IDLE);
    assign o_grant_id      = r_grant_id;
    assign o_timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter (4-client and 1-client builds).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NC = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [NC-1:0] valid, last, ready;
    logic [8*NC-1:0] data;
    logic [7:0]    tx_data;
    logic          tx_valid, tx_ready, busy, pulse;
    logic [1:0]    gid;

    logic       b_valid, b_last, b_ready, b_tx_valid, b_tx_ready, b_busy, b_pulse;
    logic [0:0] b_gid;
    logic [7:0] b_data, b_tx_data;

    uart_tx_arbiter #(
        .NUM_CLIENTS    (NC),
        .HEADER_EN      (1'b1),
        .HEADER_BASE    (8'hF0),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .i_clk (clk), .i_rst (rst), .i_valid (valid), .i_data (data), .i_last (last),
        .o_ready (ready), .o_tx_data (tx_data), .o_tx_valid (tx_valid), .i_tx_ready (tx_ready),
        .o_busy (busy), .o_grant_id (gid), .o_timeout_pulse (pulse)
    );

    uart_tx_arbiter #(
        .NUM_CLIENTS    (1),
        .HEADER_EN      (1'b0),
        .HEADER_BASE    (8'hF0),
        .TIMEOUT_CYCLES (16'd0)
    ) dut_b (
        .i_clk (clk), .i_rst (rst), .i_valid (b_valid), .i_data (b_data), .i_last (b_last),
        .o_ready (b_ready), .o_tx_data (b_tx_data), .o_tx_valid (b_tx_valid), .i_tx_ready (b_tx_ready),
        .o_busy (b_busy), .o_grant_id (b_gid), .o_timeout_pulse (b_pulse)
    );

    item_t      cq[NC][$];
    logic [7:0] exp_q[$];
    int         gap[NC];
    logic [NC-1:0] fire = '0;
    int   errors = 0, checks = 0;
    int   cyc = 0, last_xfer_cyc = 0, pulse_cnt = 0, pulse_gap = 0, b_pulse_cnt = 0;
    logic prev_pulse = 1'b0;
    int   mptr = 0;
    int   ready_mode = 0;
    logic ready_force = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_item(input int k, input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        cq[k].push_back(it);
    endtask

    // Reference: packets already queued are served whole, in round-robin order
    // starting at the pointer; each packet is led by its channel header.
    task automatic model_batch();
        item_t mq[NC][$];
        item_t it;
        int    c;
        bit    done;
        for (int k = 0; k < NC; k++) mq[k] = cq[k];
        while (1) begin
            c = -1;
            for (int s = 0; s < NC; s++) begin
                if (c < 0 && mq[(mptr + s) % NC].size() > 0) c = (mptr + s) % NC;
            end
            if (c < 0) break;
            exp_q.push_back(8'hF0 + 8'(c));
            done = 1'b0;
            while (!done && mq[c].size() > 0) begin
                it = mq[c].pop_front();
                exp_q.push_back(it.d);
                done = it.l;
            end
            mptr = (c + 1) % NC;
        end
    endtask

    function automatic bit pending();
        bit p = (exp_q.size() > 0);
        for (int k = 0; k < NC; k++) if (cq[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input int budget, input bit check_idle);
        int n = 0;
        while (pending() && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d bytes outstanding expected 0", exp_q.size());
            exp_q.delete();
            for (int k = 0; k < NC; k++) cq[k].delete();
        end
        repeat (3) @(posedge clk);
        #2;
        if (check_idle) chk("idle_after_batch", 32'(busy), 32'd0);
    endtask

    // Client and uart models: pop on the transfer seen at the preceding negedge.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NC; k++) begin
            if (fire[k] && cq[k].size() > 0) begin
                if (!cq[k][0].l && $urandom_range(0, 3) == 0) gap[k] = $urandom_range(1, 3);
                void'(cq[k].pop_front());
            end else if (gap[k] > 0) begin
                gap[k]--;
            end
            if (cq[k].size() > 0 && gap[k] == 0) begin
                valid[k]       = 1'b1;
                data[8*k +: 8] = cq[k][0].d;
                last[k]        = cq[k][0].l;
            end else begin
                valid[k]       = 1'b0;
                data[8*k +: 8] = 8'h00;
                last[k]        = 1'b0;
            end
        end
        tx_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        logic       ok;
        cyc++;
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %02h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                end
            end
            ok = ((ready & ~{NC{tx_ready}}) == '0) && ($countones(ready) <= 1);
            chk("ready_rule", 32'(ok), 32'd1);
            if (pulse) begin
                pulse_cnt++;
                pulse_gap = cyc - last_xfer_cyc;
                chk("pulse_width", 32'(prev_pulse), 32'd0);
            end
            if (b_pulse) b_pulse_cnt++;
        end
        prev_pulse = pulse;
        fire = rst ? '0 : (valid & ready);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int npk;
        rst = 1'b1;
        valid = '0; data = '0; last = '0; tx_ready = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_tx_ready = 1'b0;
        for (int k = 0; k < NC; k++) gap[k] = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(gid), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // Every client requesting from reset: order 0,1,2,3,0,...
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NC; k++) add_item(k, 8'($urandom), 1'b1);
        model_batch();
        wait_drain(1000, 1'b1);

        // Client 1 alone: F1 41 42.
        add_item(1, 8'h41, 1'b0);
        add_item(1, 8'h42, 1'b1);
        model_batch();
        wait_drain(500, 1'b1);

        // Packet lock: client 1 waits behind client 0's three bytes.
        add_item(0, 8'hA0, 1'b0);
        add_item(0, 8'hA1, 1'b0);
        add_item(0, 8'hA2, 1'b1);
        add_item(1, 8'hB0, 1'b1);
        model_batch();
        wait_drain(500, 1'b1);

        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < NC; k++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < n; i++) add_item(k, 8'($urandom), 1'(i == n - 1));
                end
            end
            model_batch();
            wait_drain(2000, 1'b1);
        end

        // Client 2 stalls mid-packet while client 3 waits.
        exp_q.push_back(8'hF2);
        exp_q.push_back(8'h5A);
        add_item(2, 8'h5A, 1'b0);
        wait_drain(500, 1'b0);
        add_item(3, 8'hC3, 1'b1);
        mptr = 3;
        model_batch();
        wait_drain(500, 1'b1);
        chk("timeout_pulse_count", 32'(pulse_cnt), 32'd1);
        chk("timeout_delay", 32'(pulse_gap), 32'd17);

        // Reset while the header is being offered.
        ready_mode = 1;
        ready_force = 1'b0;
        add_item(1, 8'hAA, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx_valid && busy) && n < 50);
        chk("hdr_before_reset", 32'(tx_data), 32'hF1);
        rst = 1'b1;
        cq[1].delete();
        @(negedge clk);
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd0);
        chk("rst_mid_gid", 32'(gid), 32'd0);
        rst = 1'b0;
        mptr = 0;
        @(posedge clk); #2;
        ready_mode = 0;
        add_item(3, 8'h33, 1'b1);
        model_batch();
        wait_drain(500, 1'b1);

        for (int k = 0; k < NC; k++) add_item(k, 8'(8'h60 + k), 1'b1);
        model_batch();
        wait_drain(1000, 1'b1);

        // Single-client build, no header, timeout disabled.
        @(posedge clk); #1;
        b_tx_ready = 1'b1; b_valid = 1'b1; b_data = 8'h11; b_last = 1'b0;
        @(negedge clk);
        chk("b_grant_latency", 32'(b_tx_valid), 32'd0);
        @(negedge clk);
        chk("b_pass_valid", 32'(b_tx_valid), 32'd1);
        chk("b_pass_data", 32'(b_tx_data), 32'h11);
        chk("b_pass_ready", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0; b_data = 8'h00;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("b_stall_busy", 32'(b_busy), 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b1; b_data = 8'h55; b_last = 1'b1; b_tx_ready = 1'b0;
        @(negedge clk);
        chk("b_data_55", 32'(b_tx_data), 32'h55);
        chk("b_valid_55", 32'(b_tx_valid), 32'd1);
        chk("b_ready_busy_uart", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        b_tx_ready = 1'b1;
        @(negedge clk);
        chk("b_ready_55", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
        b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
        @(negedge clk);
        chk("b_idle_busy", 32'(b_busy), 32'd0);
        chk("b_idle_valid", 32'(b_tx_valid), 32'd0);
        chk("b_gid", 32'(b_gid), 32'd0);
        chk("b_pulse_count", 32'(b_pulse_cnt), 32'd0);
        chk("final_pulse_count", 32'(pulse_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
